// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: redirect-driven PC generation, req/gnt/rvalid memory
// handshake with up to DEPTH requests in flight, and a DEPTH-entry FIFO to decode.
package if_fetch_pkg;
    typedef enum logic [2:0] {
        PC_BOOT = 3'd0,
        PC_NEXT = 3'd1,
        PC_JUMP = 3'd2,
        PC_EXC  = 3'd3,
        PC_ERET = 3'd4,
        PC_DRET = 3'd5
    } pc_sel_e;

    typedef enum logic [1:0] {
        EXC_PC_EXC     = 2'd0,
        EXC_PC_IRQ     = 2'd1,
        EXC_PC_DBD     = 2'd2,
        EXC_PC_DBG_EXC = 2'd3
    } exc_pc_sel_e;
endpackage

module if_fetch_stage
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR    = 32'h0000_0080,
    parameter logic [31:0] DM_HALT_ADDR = 32'h1A11_0800,
    parameter logic [31:0] DM_EXC_ADDR  = 32'h1A11_0808,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable_i,
    input  logic        pc_set_i,
    input  pc_sel_e     pc_mux_i,
    input  exc_pc_sel_e exc_pc_mux_i,
    input  logic [4:0]  irq_id_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_depc_i,
    input  logic        instr_valid_clear_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fetch_err_o,
    input  logic        id_ready_i,
    output logic        if_busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] mem_rdata_q [DEPTH];
    logic [31:0] mem_pc_q    [DEPTH];
    logic        mem_err_q   [DEPTH];

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [CW:0] occupancy;
    logic        gnt_fire;
    logic        rvalid_ok;
    logic        push;
    logic        pop;

    // PC_NEXT (and undefined selects) never redirect, even with pc_set_i high.
    always_comb begin
        redirect   = 1'b0;
        target_raw = BOOT_ADDR;
        if (pc_set_i) begin
            case (pc_mux_i)
                PC_BOOT: begin redirect = 1'b1; target_raw = BOOT_ADDR;     end
                PC_JUMP: begin redirect = 1'b1; target_raw = jump_target_i; end
                PC_ERET: begin redirect = 1'b1; target_raw = csr_mepc_i;    end
                PC_DRET: begin redirect = 1'b1; target_raw = csr_depc_i;    end
                PC_EXC: begin
                    redirect = 1'b1;
                    case (exc_pc_mux_i)
                        EXC_PC_EXC: target_raw = {csr_mtvec_i[31:8], 8'h00};
                        EXC_PC_IRQ: target_raw = {csr_mtvec_i[31:8], 1'b0, irq_id_i, 2'b00};
                        EXC_PC_DBD: target_raw = DM_HALT_ADDR;
                        default:    target_raw = DM_EXC_ADDR;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign target = {target_raw[31:2], 2'b00};

    // Requests are only issued when every in-flight word is guaranteed a FIFO slot.
    assign occupancy   = {1'b0, count_q} + {1'b0, outstanding_q};
    assign instr_req_o = fetch_enable_i & (occupancy < DEPTH_OCC);
    assign gnt_fire    = instr_req_o & instr_gnt_i;
    assign rvalid_ok   = instr_rvalid_i & (outstanding_q != '0);
    assign push        = rvalid_ok & (discard_q == '0) & ~redirect;
    assign pop         = instr_valid_o & (id_ready_i | instr_valid_clear_i);

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (gnt_fire && !rvalid_ok) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!gnt_fire && rvalid_ok) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old stream,
            // including a request granted in this very cycle.
            fetch_addr_d = target;
            resp_pc_d    = target;
            discard_d    = outstanding_d;
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (gnt_fire) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (rvalid_ok && discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q  <= BOOT_ADDR;
            resp_pc_q     <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rdata_q[wr_ptr_q] <= instr_rdata_i;
            mem_pc_q[wr_ptr_q]    <= resp_pc_q;
            mem_err_q[wr_ptr_q]   <= instr_err_i;
        end
    end

    assign instr_addr_o      = fetch_addr_q;
    assign instr_valid_o     = (count_q != '0);
    assign instr_rdata_o     = instr_valid_o ? mem_rdata_q[rd_ptr_q] : 32'h0;
    assign instr_pc_o        = instr_valid_o ? mem_pc_q[rd_ptr_q] : 32'h0;
    assign instr_fetch_err_o = instr_valid_o & mem_err_q[rd_ptr_q];
    assign if_busy_o         = instr_req_o | (outstanding_q != '0);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: redirect-target table, directed multi-cycle sequences and
// randomized traffic against a queue-based model of the fetch stream.
module tb_if_fetch_stage;
    import if_fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0080;
    localparam logic [31:0] HALT  = 32'h1A11_0800;
    localparam logic [31:0] DEXC  = 32'h1A11_0808;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_enable_i, pc_set_i, instr_valid_clear_i;
    pc_sel_e     pc_mux_i;
    exc_pc_sel_e exc_pc_mux_i;
    logic [4:0]  irq_id_i;
    logic [31:0] jump_target_i, csr_mtvec_i, csr_mepc_i, csr_depc_i;
    logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        instr_valid_o, instr_fetch_err_o, id_ready_i, if_busy_o;
    logic [31:0] instr_rdata_o, instr_pc_o;

    if_fetch_stage #(
        .BOOT_ADDR(BOOT), .DM_HALT_ADDR(HALT), .DM_EXC_ADDR(DEXC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_enable_i(fetch_enable_i), .pc_set_i(pc_set_i), .pc_mux_i(pc_mux_i),
        .exc_pc_mux_i(exc_pc_mux_i), .irq_id_i(irq_id_i), .jump_target_i(jump_target_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_depc_i(csr_depc_i),
        .instr_valid_clear_i(instr_valid_clear_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o), .instr_pc_o(instr_pc_o),
        .instr_fetch_err_o(instr_fetch_err_o), .id_ready_i(id_ready_i), .if_busy_o(if_busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit verbose = 1'b1;

    // Stimulus for the next cycle
    logic        s_en, s_rdy, s_clr, s_pset, s_gnt, s_rv;
    pc_sel_e     s_pmux;
    exc_pc_sel_e s_emux;
    logic [4:0]  s_irq;
    logic [31:0] s_jt, s_mtvec, s_mepc, s_depc;

    // Reference model: fetch address, in-flight requests (with stale marks), FIFO contents
    logic [31:0] m_fetch;
    logic [31:0] m_infl[$];
    bit          m_stale[$];
    logic [31:0] m_fifo[$];
    logic [31:0] glog[$];
    logic [31:0] plog[$];

    typedef struct {
        pc_sel_e     pmux;
        exc_pc_sel_e emux;
        logic [4:0]  irq;
        logic [31:0] jt, mtvec, mepc, depc, exp;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[3:2] == 2'b01;
    endfunction

    function automatic logic [31:0] exp_target(input pc_sel_e m, input exc_pc_sel_e e,
            input logic [4:0] id, input logic [31:0] j, input logic [31:0] mt,
            input logic [31:0] ep, input logic [31:0] dp);
        logic [31:0] t;
        case (m)
            PC_BOOT: t = BOOT;
            PC_JUMP: t = j;
            PC_ERET: t = ep;
            PC_DRET: t = dp;
            PC_EXC: begin
                if (e == EXC_PC_EXC)      t = {mt[31:8], 8'h00};
                else if (e == EXC_PC_IRQ) t = {mt[31:8], 8'h00} + {25'd0, id, 2'b00};
                else if (e == EXC_PC_DBD) t = HALT;
                else                      t = DEXC;
            end
            default: t = 32'h0;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        fetch_enable_i = 0; pc_set_i = 0; instr_valid_clear_i = 0; id_ready_i = 0;
        pc_mux_i = PC_NEXT; exc_pc_mux_i = EXC_PC_EXC; irq_id_i = 0; jump_target_i = 0;
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_depc_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        s_en = 0; s_pset = 0; s_clr = 0; s_rdy = 0; s_gnt = 0; s_rv = 0;
        m_fifo.delete(); m_infl.delete(); m_stale.delete();
        m_fetch = BOOT;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_rdata", instr_rdata_o, 32'h0);
        chk("rst_pc", instr_pc_o, 32'h0);
        chk("rst_err", 32'(instr_fetch_err_o), 32'h0);
        chk("rst_req", 32'(instr_req_o), 32'h0);
        chk("rst_addr", instr_addr_o, BOOT);
        chk("rst_busy", 32'(if_busy_o), 32'h0);
    endtask

    // One clock: drive stimulus, compare outputs to the model, then advance the model.
    task automatic cycle();
        logic [31:0] front, tgt, head;
        bit do_rv, exp_req, redir, fired, st;
        @(negedge clk);
        do_rv = s_rv && (m_infl.size() != 0);
        front = do_rv ? m_infl[0] : 32'h0;
        head  = (m_fifo.size() != 0) ? m_fifo[0] : 32'h0;
        fetch_enable_i = s_en; id_ready_i = s_rdy; instr_valid_clear_i = s_clr;
        pc_set_i = s_pset; pc_mux_i = s_pmux; exc_pc_mux_i = s_emux; irq_id_i = s_irq;
        jump_target_i = s_jt; csr_mtvec_i = s_mtvec; csr_mepc_i = s_mepc; csr_depc_i = s_depc;
        instr_gnt_i = s_gnt; instr_rvalid_i = do_rv;
        instr_rdata_i = do_rv ? mem_word(front) : 32'h0;
        instr_err_i = do_rv ? mem_err(front) : 1'b0;
        #1;
        exp_req = s_en && ((m_fifo.size() + m_infl.size()) < DEPTH);
        chk("req", 32'(instr_req_o), 32'(exp_req));
        if (exp_req) chk("fetch_addr", instr_addr_o, m_fetch);
        chk("busy", 32'(if_busy_o), 32'(exp_req || m_infl.size() != 0));
        chk("valid", 32'(instr_valid_o), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk("head_pc", instr_pc_o, head);
            chk("head_rdata", instr_rdata_o, mem_word(head));
            chk("head_err", 32'(instr_fetch_err_o), 32'(mem_err(head)));
        end

        redir = s_pset && (s_pmux != PC_NEXT);
        tgt   = exp_target(s_pmux, s_emux, s_irq, s_jt, s_mtvec, s_mepc, s_depc);
        fired = exp_req && s_gnt;
        if (m_fifo.size() != 0 && (s_rdy || s_clr)) begin
            if (verbose) $display("pop pc=%08h rdata=%08h err=%0d clear=%0d",
                                  head, instr_rdata_o, instr_fetch_err_o, s_clr);
            plog.push_back(head);
            void'(m_fifo.pop_front());
        end
        if (do_rv) begin
            st = m_stale.pop_front();
            void'(m_infl.pop_front());
            if (!st && !redir) m_fifo.push_back(front);
        end
        if (fired) begin
            glog.push_back(m_fetch);
            m_infl.push_back(m_fetch);
            m_stale.push_back(1'b0);
            m_fetch = m_fetch + 32'd4;
        end
        if (redir) begin
            m_fifo.delete();
            foreach (m_stale[i]) m_stale[i] = 1'b1;
            m_fetch = tgt;
        end
    endtask

    task automatic drain();
        s_en = 0; s_pset = 0; s_clr = 0; s_rdy = 1; s_rv = 1; s_gnt = 0;
        repeat (6) cycle();
    endtask

    initial begin
        int gi, pi;
        rst_n = 1'b0;
        drive_idle();
        s_pmux = PC_NEXT; s_emux = EXC_PC_EXC; s_irq = 0;
        s_jt = 0; s_mtvec = 0; s_mepc = 0; s_depc = 0;

        vecs[0]  = '{PC_JUMP, EXC_PC_EXC,     5'd0,  32'h0000_1000, 32'h0, 32'h0, 32'h0, 32'h0000_1000};
        vecs[1]  = '{PC_JUMP, EXC_PC_EXC,     5'd0,  32'h0000_2003, 32'h0, 32'h0, 32'h0, 32'h0000_2000};
        vecs[2]  = '{PC_EXC,  EXC_PC_IRQ,     5'd7,  32'h0, 32'h0000_0101, 32'h0, 32'h0, 32'h0000_011C};
        vecs[3]  = '{PC_EXC,  EXC_PC_EXC,     5'd3,  32'h0, 32'h1234_56FF, 32'h0, 32'h0, 32'h1234_5600};
        vecs[4]  = '{PC_EXC,  EXC_PC_IRQ,     5'd31, 32'h0, 32'hABCD_EF00, 32'h0, 32'h0, 32'hABCD_EF7C};
        vecs[5]  = '{PC_EXC,  EXC_PC_DBD,     5'd0,  32'h0, 32'h0000_0101, 32'h0, 32'h0, 32'h1A11_0800};
        vecs[6]  = '{PC_EXC,  EXC_PC_DBG_EXC, 5'd0,  32'h0, 32'h0000_0101, 32'h0, 32'h0, 32'h1A11_0808};
        vecs[7]  = '{PC_ERET, EXC_PC_EXC,     5'd0,  32'h0, 32'h0, 32'h0000_4446, 32'h0, 32'h0000_4444};
        vecs[8]  = '{PC_DRET, EXC_PC_EXC,     5'd0,  32'h0, 32'h0, 32'h0, 32'h8000_0007, 32'h8000_0004};
        vecs[9]  = '{PC_NEXT, EXC_PC_EXC,     5'd0,  32'h0000_5000, 32'h0, 32'h0, 32'h0, 32'h8000_0004};
        vecs[10] = '{PC_BOOT, EXC_PC_EXC,     5'd0,  32'h0000_5000, 32'h0, 32'h0, 32'h0, 32'h0000_0080};

        do_reset();

        // Redirect target table, fetch disabled
        for (int i = 0; i < 11; i++) begin
            s_en = 0; s_gnt = 0; s_rv = 0; s_rdy = 1; s_clr = 0;
            s_pset = 1; s_pmux = vecs[i].pmux; s_emux = vecs[i].emux; s_irq = vecs[i].irq;
            s_jt = vecs[i].jt; s_mtvec = vecs[i].mtvec; s_mepc = vecs[i].mepc; s_depc = vecs[i].depc;
            cycle();
            s_pset = 0;
            cycle();
            chk("redirect_addr", instr_addr_o, vecs[i].exp);
            $display("redirect vec=%0d pc_mux=%0d exc_mux=%0d addr=%08h", i, vecs[i].pmux,
                     vecs[i].emux, instr_addr_o);
        end

        // Boot streaming: gnt every cycle, response one cycle after grant
        glog.delete(); plog.delete();
        s_en = 1; s_gnt = 1; s_rv = 1; s_rdy = 1; s_clr = 0; s_pset = 0;
        repeat (12) cycle();
        chk("boot_gnt0", glog[0], 32'h80);
        chk("boot_gnt1", glog[1], 32'h84);
        chk("boot_gnt2", glog[2], 32'h88);
        chk("boot_pop0", plog[0], 32'h80);
        chk("boot_pop1", plog[1], 32'h84);

        // Decode stalled for 5 cycles: at most DEPTH grants, then req stays low
        drain();
        gi = glog.size();
        s_en = 1; s_gnt = 1; s_rv = 1; s_rdy = 0;
        repeat (5) cycle();
        chk("stall_gnts", 32'(glog.size() - gi), 32'(DEPTH));
        chk("stall_req", 32'(instr_req_o), 32'h0);
        s_rdy = 1;
        repeat (6) cycle();

        // Redirect with two requests outstanding
        drain();
        s_en = 1; s_gnt = 1; s_rv = 0; s_rdy = 1;
        repeat (2) cycle();
        gi = glog.size(); pi = plog.size();
        s_pset = 1; s_pmux = PC_JUMP; s_jt = 32'h0000_1000;
        cycle();
        s_pset = 0; s_rv = 1;
        repeat (8) cycle();
        chk("jump_gnt0", glog[gi], 32'h0000_1000);
        chk("jump_gnt1", glog[gi + 1], 32'h0000_1004);
        chk("jump_pop0", plog[pi], 32'h0000_1000);

        // Address wrap past 2^32
        drain();
        s_pset = 1; s_pmux = PC_JUMP; s_jt = 32'hFFFF_FFF8;
        cycle();
        gi = glog.size();
        s_pset = 0; s_en = 1; s_gnt = 1; s_rv = 1; s_rdy = 1;
        repeat (8) cycle();
        chk("wrap_gnt0", glog[gi], 32'hFFFF_FFF8);
        chk("wrap_gnt1", glog[gi + 1], 32'hFFFF_FFFC);
        chk("wrap_gnt2", glog[gi + 2], 32'h0000_0000);

        // Fetch disabled with one request outstanding; PC_NEXT set is ignored
        drain();
        s_en = 1; s_gnt = 1; s_rv = 0; s_rdy = 0;
        cycle();
        s_en = 0; s_pset = 1; s_pmux = PC_NEXT;
        cycle();
        s_pset = 0; s_rv = 1;
        cycle();
        s_rv = 0;
        cycle();
        chk("drop_en_busy", 32'(if_busy_o), 32'h0);
        chk("drop_en_valid", 32'(instr_valid_o), 32'h1);
        chk("drop_en_pc", instr_pc_o, glog[glog.size() - 1]);

        // Randomized traffic with one mid-run reset
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            s_en    = ($urandom_range(0, 9) != 0);
            s_rdy   = ($urandom_range(0, 3) != 0);
            s_clr   = ($urandom_range(0, 19) == 0);
            s_pset  = ($urandom_range(0, 24) == 0);
            s_pmux  = pc_sel_e'($urandom_range(0, 5));
            s_emux  = exc_pc_sel_e'($urandom_range(0, 3));
            s_irq   = 5'($urandom);
            s_jt    = $urandom;
            s_mtvec = $urandom;
            s_mepc  = $urandom;
            s_depc  = $urandom;
            s_gnt   = ($urandom_range(0, 2) != 0);
            s_rv    = ($urandom_range(0, 1) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
